// File: rtl/shift_seq16_if.sv
//------------------------------------------------------------------------------
// Module : shift_seq16_if
// Brief  : Request/response bundle between the two shift requesters, the
//          result consumer and the shift_seq16 sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_seq16_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_data;
  logic [15:0] req1_data;
  logic [3:0]  req0_amt;
  logic [3:0]  req1_amt;
  logic        req0_dir;
  logic        req1_dir;
  logic [1:0]  req0_mode;
  logic [1:0]  req1_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_id;
  logic        busy;

  modport master (
    output req_valid, req0_data, req1_data, req0_amt, req1_amt,
           req0_dir, req1_dir, req0_mode, req1_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id, busy
  );

  modport slave (
    input  req_valid, req0_data, req1_data, req0_amt, req1_amt,
           req0_dir, req1_dir, req0_mode, req1_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/shift_seq16.sv
//------------------------------------------------------------------------------
// Module : shift_seq16
// Brief  : Round-robin arbiter plus bit-serial (one bit per clock) 16-bit shift
//          sequencer. Define SHIFT_SEQ16_ROTATE_EN to enable rotate mode (10).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_seq16 #(
  parameter logic FILL_VAL = 1'b0
) (
  input  wire logic     clock,
  input  wire logic     reset,
  shift_seq16_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_MODE_ARITH = 2'b01;
  localparam logic [1:0] c_MODE_ROT   = 2'b10;

  state_t      r_state;
  logic [15:0] r_w;
  logic [3:0]  r_cnt;
  logic        r_carry;
  logic        r_id;
  logic        r_prio;
  logic        r_dir;
  logic [1:0]  r_mode;
  logic        r_rsp_valid;
  logic        r_busy;

  logic        w_any;
  logic        w_grant;
  logic [15:0] w_sel_data;
  logic [3:0]  w_sel_amt;
  logic        w_sel_dir;
  logic [1:0]  w_sel_mode;
  logic        w_out;
  logic        w_fill;
  logic [15:0] w_next;

  // Requester 1 wins only when it is alone or the pointer favours it.
  assign w_any   = |bus.req_valid;
  assign w_grant = bus.req_valid[1] & (~bus.req_valid[0] | r_prio);

  assign w_sel_data = w_grant ? bus.req1_data : bus.req0_data;
  assign w_sel_amt  = w_grant ? bus.req1_amt  : bus.req0_amt;
  assign w_sel_dir  = w_grant ? bus.req1_dir  : bus.req0_dir;
  assign w_sel_mode = w_grant ? bus.req1_mode : bus.req0_mode;

  assign bus.req_ready = (r_state == ST_IDLE && w_any) ?
                         (w_grant ? 2'b10 : 2'b01) : 2'b00;

  assign w_out = r_dir ? r_w[15] : r_w[0];

  always_comb begin
    w_fill = FILL_VAL;
    if (r_mode == c_MODE_ARITH && !r_dir) begin
      w_fill = r_w[15];
    end
`ifdef SHIFT_SEQ16_ROTATE_EN
    if (r_mode == c_MODE_ROT) begin
      w_fill = w_out;
    end
`endif
  end

  assign w_next = r_dir ? {r_w[14:0], w_fill} : {w_fill, r_w[15:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_w         <= 16'h0000;
      r_cnt       <= 4'd0;
      r_carry     <= 1'b0;
      r_id        <= 1'b0;
      r_prio      <= 1'b0;
      r_dir       <= 1'b0;
      r_mode      <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_w     <= w_sel_data;
            r_cnt   <= w_sel_amt;
            r_carry <= 1'b0;
            r_id    <= w_grant;
            r_prio  <= ~w_grant;
            r_dir   <= w_sel_dir;
            r_mode  <= w_sel_mode;
            r_busy  <= 1'b1;
            if (w_sel_amt == 4'd0) begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_w     <= w_next;
          r_carry <= w_out;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_w;
  assign bus.rsp_carry = r_carry;
  assign bus.rsp_id    = r_id;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq16.sv
//------------------------------------------------------------------------------
// Module : tb_shift_seq16
// Brief  : Directed vector bench for shift_seq16 (honours SHIFT_SEQ16_ROTATE_EN).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_seq16;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  shift_seq16_if bus ();

  shift_seq16 #(.FILL_VAL(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        k;
    logic [15:0] data;
    logic [3:0]  amt;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] exp_data;
    logic        exp_carry;
  } vec_t;

`ifdef SHIFT_SEQ16_ROTATE_EN
  localparam logic [15:0] c_ROT_L = 16'h2341;
  localparam logic [15:0] c_ROT_R = 16'h1842;
`else
  localparam logic [15:0] c_ROT_L = 16'h2340;
  localparam logic [15:0] c_ROT_R = 16'h0842;
`endif

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic k, input logic [15:0] d, input logic [3:0] a,
                         input logic dr, input logic [1:0] m);
    if (k) begin
      bus.req1_data = d; bus.req1_amt = a; bus.req1_dir = dr; bus.req1_mode = m;
    end else begin
      bus.req0_data = d; bus.req0_amt = a; bus.req0_dir = dr; bus.req0_mode = m;
    end
  endtask

  // Issue one command from a negedge, check latency and result, then retire it.
  task automatic run_vec(input vec_t v);
    int lat;
    set_req(v.k, v.data, v.amt, v.dir, v.mode);
    bus.req_valid = v.k ? 2'b10 : 2'b01;
    #1;
    chk("req_ready", {30'd0, bus.req_ready}, v.k ? 32'd2 : 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 2'b00;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, v.amt + 1);
    chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, v.exp_data});
    chk("rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, v.exp_carry});
    chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, v.k});
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("idle_after_rsp", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    logic seen;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{1'b0, 16'h8001, 4'd1,  1'b1, 2'b00, 16'h0002, 1'b1};
    vecs[1] = '{1'b1, 16'h8000, 4'd15, 1'b0, 2'b01, 16'hFFFF, 1'b0};
    vecs[2] = '{1'b0, 16'h1234, 4'd4,  1'b1, 2'b10, c_ROT_L,  1'b1};
    vecs[3] = '{1'b1, 16'hF00F, 4'd4,  1'b0, 2'b00, 16'h0F00, 1'b1};
    vecs[4] = '{1'b0, 16'h8001, 4'd3,  1'b1, 2'b01, 16'h0008, 1'b0};
    vecs[5] = '{1'b1, 16'h8421, 4'd4,  1'b0, 2'b10, c_ROT_R,  1'b0};
    vecs[6] = '{1'b0, 16'h00FF, 4'd8,  1'b1, 2'b11, 16'hFF00, 1'b0};
    vecs[7] = '{1'b1, 16'h7FFE, 4'd1,  1'b0, 2'b01, 16'h3FFF, 1'b0};
    vecs[8] = '{1'b0, 16'h8000, 4'd2,  1'b0, 2'b01, 16'hE000, 1'b0};

    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 16'h0, 4'd0, 1'b0, 2'b00);
    set_req(1'b1, 16'h0, 4'd0, 1'b0, 2'b00);
    @(negedge clock);
    do_reset();

    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("rst_rsp_carry", {31'd0, bus.rsp_carry}, 32'd0);
    chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Zero amount with 5 cycles of backpressure; requester 1 waits meanwhile.
    set_req(1'b0, 16'hA5A5, 4'd0, 1'b1, 2'b00);
    bus.req_valid = 2'b01;
    #1;
    chk("bp_accept", {30'd0, bus.req_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    set_req(1'b1, 16'h1111, 4'd2, 1'b1, 2'b00);
    bus.req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_data", {16'd0, bus.rsp_data}, 32'h0000A5A5);
      chk("bp_rsp_carry", {31'd0, bus.rsp_carry}, 32'd0);
      chk("bp_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
      chk("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("bp_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clock);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("bp_idle", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);

    // Continuous contention from reset: grants must alternate 0,1,0,1.
    do_reset();
    set_req(1'b0, 16'h0001, 4'd1, 1'b1, 2'b00);
    set_req(1'b1, 16'h0100, 4'd1, 1'b0, 2'b00);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      #1;
      while (bus.req_ready == 2'b00 && cnt < 40) begin
        @(negedge clock);
        #1;
        cnt++;
      end
      chk("arb_grant", {30'd0, bus.req_ready}, (i % 2) ? 32'd2 : 32'd1);
      @(posedge clock);
      @(negedge clock);
      cnt = 0;
      while (!bus.rsp_valid && cnt < 40) begin
        @(negedge clock);
        cnt++;
      end
      chk("arb_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("arb_rsp_id", {31'd0, bus.rsp_id}, (i % 2) ? 32'd1 : 32'd0);
      chk("arb_rsp_data", {16'd0, bus.rsp_data}, (i % 2) ? 32'h0080 : 32'h0002);
      @(negedge clock);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    @(negedge clock);

    // Reset in the middle of an amt=10 shift drops the command.
    set_req(1'b0, 16'hFFFF, 4'd10, 1'b1, 2'b00);
    bus.req_valid = 2'b01;
    #1;
    chk("mid_accept", {30'd0, bus.req_ready}, 32'd1);
    @(posedge clock);
    repeat (3) @(negedge clock);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {30'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_data", {16'd0, bus.rsp_data}, 32'd0);
    reset = 1'b0;
    bus.req_valid = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", {31'd0, seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_seq16.md
# shift_seq16

Sequencer and arbiter for the 16-bit bit-serial shift datapath. Accepts shift commands from two requesters, with round-robin arbitration between them. Executes a multi-bit shift as a sequence of one-bit shift steps, one step per clock, on an internal 16-bit working register. Returns the result, the last bit shifted out and the requester tag on a valid/ready response port. Sits between the ALU issue logic and the shift datapath.

## Interface
- FILL_VAL, 1'b0, fill bit inserted by logical-mode shifts
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit k: requester k presents a command
- req_ready  out  2  bit k: command of requester k accepted this cycle
- req0_data / req1_data  in  16  operand
- req0_amt / req1_amt  in  4  shift amount 0..15
- req0_dir / req1_dir  in  1  1 = left, 0 = right
- req0_mode / req1_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as 00
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  shifted value
- rsp_carry  out  1  last bit shifted out (0 when amt = 0)
- rsp_id  out  1  requester that issued the command
- busy  out  1  high in SHIFT or DONE

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - grant = the only valid requester, or, if both are valid, the requester selected by the priority pointer `prio`.
  - req_ready[grant] = 1 combinationally. The other bit is 0.
  - On accept: w ← data, cnt ← amt, carry ← 0, id ← grant, prio ← ~grant.
  - Next state is DONE if amt = 0, otherwise SHIFT.
- **SHIFT, once per cycle:**
  - Left step: out = w[15], w ← {w[14:0], fill}.
  - Right step: out = w[0], w ← {fill, w[15:1]}.
  - Each step: carry ← out, cnt ← cnt − 1. When cnt = 1 before the step, next state is DONE.
- **Fill bit:**
  - Logical: FILL_VAL.
  - Arithmetic right: w[15].
  - Arithmetic left: same as logical.
  - Rotate: out.
- **DONE:** rsp_valid = 1 and rsp_data = w, rsp_carry = carry, rsp_id = id, all held stable. On rsp_ready = 1, go to IDLE.
- **Commands while not IDLE:** req_ready = 0. Requesters hold their commands; there is no queueing.
- **Widths:** cnt is 4 bits. amt = 15 performs exactly 15 steps with no wrap.
- **Reset:** state ← IDLE, prio ← 0 (requester 0 wins ties), w ← 0, cnt ← 0, carry ← 0, id ← 0.
  - Outputs after reset: rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_id = 0, busy = 0.
  - req_ready is combinational and equals the grant in IDLE.
  - A reset asserted in SHIFT or DONE drops the in-flight command; no response is produced for it.

## Timing
- Accept handshake in cycle T gives rsp_valid from cycle T+1+amt.
  - amt = 0: rsp_valid in cycle T+1.
  - amt = 15: rsp_valid in cycle T+16.
- rsp_valid stays high until the handshake cycle. The FSM is in IDLE on the next cycle, and a new accept is possible in that cycle.
- Maximum throughput: one command per amt+2 cycles.
- req_ready depends combinationally on req_valid and state; there is no combinational path from rsp_ready.
- Simultaneous valid on both requesters: exactly one is granted. The loser is granted at the next IDLE if it is still valid, so grants strictly alternate under continuous contention.

## Configuration
- **SHIFT_SEQ16_ROTATE_EN defined:** mode 10 rotates as described above.
- **Not defined:** mode 10 behaves exactly as logical (fill = FILL_VAL), and the rotate fill path is not synthesised.

## Test plan
- **Logical left:** req0 {data=16'h8001, amt=1, dir=1, mode=00} → rsp_data=16'h0002, carry=1, id=0, rsp_valid 2 cycles after accept.
- **Arithmetic right:** req1 {data=16'h8000, amt=15, dir=0, mode=01} → rsp_data=16'hFFFF, carry=0, id=1, rsp_valid at T+16.
- **Rotate (macro defined):** {data=16'h1234, amt=4, dir=1, mode=10} → rsp_data=16'h2341, carry=1. Without the macro → rsp_data=16'h2340, carry=1.
- **Zero amount and backpressure:** {data=16'hA5A5, amt=0}, hold rsp_ready=0 for 5 cycles → rsp_data=16'hA5A5, carry=0. Outputs stay stable across the 5 cycles, and req_ready stays 0 throughout.
- **Arbitration:** both requesters valid continuously after reset → grants alternate 0, 1, 0, 1, with rsp_id matching the grant order.
- **Reset mid-shift:** assert reset during SHIFT of an amt=10 command → next cycle busy=0, rsp_valid=0, no response is ever produced for it, and req_ready[0]=1 if req0 is valid.
